// File: rtl/pe_cluster_ctrl.sv
// Sequencer for one PE cluster: validates and latches a job, streams weights then ifmap
// into the cluster, and captures cluster outputs into a first-word-fall-through FIFO.
module pe_cluster_ctrl #(
    parameter int DATA_WIDTH       = 16,
    parameter int MAX_FILTER_WIDTH = 11,
    parameter int MAX_ROW_NUM      = 16,
    parameter int LEN_WIDTH        = 16,
    parameter int OFIFO_DEPTH      = 8,
    parameter int SKID             = 4,
    localparam int LOG_MFW         = $clog2(MAX_FILTER_WIDTH),
    localparam int LOG_MRN         = $clog2(MAX_ROW_NUM)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [LOG_MFW:0]      cfg_filter_width,
    input  logic [LOG_MRN:0]      cfg_row_num,
    input  logic [LOG_MFW:0]      cfg_stride,
    input  logic [LEN_WIDTH-1:0]  cfg_ifmap_len,
    input  logic [LEN_WIDTH-1:0]  cfg_out_count,
    output logic                  busy,
    output logic                  done,
    output logic                  cfg_err,
    output logic                  ovf_err,
    input  logic [DATA_WIDTH-1:0] w_data,
    input  logic                  w_valid,
    output logic                  w_ready,
    input  logic [DATA_WIDTH-1:0] x_data,
    input  logic                  x_valid,
    output logic                  x_ready,
    output logic [LOG_MFW:0]      pe_filter_width,
    output logic [MAX_ROW_NUM-1:0] pe_row_en,
    output logic [LOG_MRN:0]      pe_row_num,
    output logic [LOG_MFW:0]      pe_stride,
    output logic [DATA_WIDTH-1:0] pe_weight_data,
    output logic                  pe_weight_valid,
    output logic [DATA_WIDTH-1:0] pe_ifmap_data,
    output logic                  pe_ifmap_valid,
    output logic                  pe_reset_ifmap,
    input  logic [DATA_WIDTH-1:0] pe_peout_data,
    input  logic                  pe_peout_valid,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_valid,
    input  logic                  o_ready
);

    localparam int WCNT_W = LOG_MFW + LOG_MRN + 2;
    localparam int FPTR_W = $clog2(OFIFO_DEPTH);
    localparam int FCNT_W = FPTR_W + 1;

    localparam logic [LOG_MFW:0]     F_MAX     = (LOG_MFW + 1)'(MAX_FILTER_WIDTH);
    localparam logic [LOG_MRN:0]     R_MAX     = (LOG_MRN + 1)'(MAX_ROW_NUM);
    localparam logic [FCNT_W-1:0]    X_LIMIT   = FCNT_W'(OFIFO_DEPTH - SKID);
    localparam logic [FCNT_W-1:0]    FIFO_FULL = FCNT_W'(OFIFO_DEPTH);
    localparam logic [WCNT_W-1:0]    WCNT_ONE  = WCNT_W'(1);
    localparam logic [LEN_WIDTH-1:0] LEN_ONE   = LEN_WIDTH'(1);
    localparam logic [FPTR_W-1:0]    PTR_ONE   = FPTR_W'(1);
    localparam logic [FCNT_W-1:0]    FCNT_ONE  = FCNT_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_W,
        ST_LOAD_I,
        ST_DRAIN,
        ST_DONE
    } state_t;

    state_t r_state, w_state_next;

    logic [WCNT_W-1:0]    r_wcnt, r_wtarget;
    logic [LEN_WIDTH-1:0] r_xcnt, r_ifmap_len, r_out_cnt, r_out_count;
    logic [FPTR_W-1:0]    r_wptr, r_rptr;
    logic [FCNT_W-1:0]    r_fifo_cnt;
    logic [DATA_WIDTH-1:0] r_mem [OFIFO_DEPTH];

    logic w_w_rdy, w_x_rdy, w_start_ok, w_start_bad, w_cfg_legal;
    logic w_w_acc, w_x_acc, w_pop, w_full, w_do_push, w_ovf;
    logic [MAX_ROW_NUM-1:0] w_row_en;

    assign w_cfg_legal = (cfg_filter_width != '0) && (cfg_filter_width <= F_MAX) &&
                         (cfg_row_num != '0) && (cfg_row_num <= R_MAX) &&
                         (cfg_stride != '0) && (cfg_ifmap_len != '0);

    for (genvar gi = 0; gi < MAX_ROW_NUM; gi++) begin : g_row_en
        assign w_row_en[gi] = ((LOG_MRN + 1)'(gi) < cfg_row_num);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_w_rdy      = 1'b0;
        w_x_rdy      = 1'b0;
        w_start_ok   = 1'b0;
        w_start_bad  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    if (w_cfg_legal) begin
                        w_start_ok   = 1'b1;
                        w_state_next = ST_LOAD_W;
                    end else begin
                        w_start_bad  = 1'b1;
                    end
                end
            end
            ST_LOAD_W: begin
                w_w_rdy = 1'b1;
                if (w_valid && ((r_wcnt + WCNT_ONE) == r_wtarget)) w_state_next = ST_LOAD_I;
            end
            ST_LOAD_I: begin
                // pe_reset_ifmap doubles as the first-cycle flag so the reset lands before any data
                w_x_rdy = !pe_reset_ifmap && (r_fifo_cnt < X_LIMIT);
                if (x_valid && w_x_rdy && ((r_xcnt + LEN_ONE) == r_ifmap_len)) w_state_next = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (r_out_cnt == r_out_count) w_state_next = ST_DONE;
            end
            ST_DONE:  w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    assign w_ready = w_w_rdy;
    assign x_ready = w_x_rdy;
    assign busy    = (r_state != ST_IDLE);
    assign done    = (r_state == ST_DONE);
    assign w_w_acc = w_valid & w_w_rdy;
    assign w_x_acc = x_valid & w_x_rdy;

    // Push is never refused from the cluster side; a push into a full FIFO only survives if a pop frees a slot.
    assign w_full    = (r_fifo_cnt == FIFO_FULL);
    assign o_valid   = (r_fifo_cnt != '0);
    assign w_pop     = o_valid & o_ready;
    assign w_do_push = pe_peout_valid & (~w_full | w_pop);
    assign w_ovf     = pe_peout_valid & w_full & ~w_pop;
    assign o_data    = o_valid ? r_mem[r_rptr] : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cfg_err         <= 1'b0;
            ovf_err         <= 1'b0;
            pe_filter_width <= '0;
            pe_row_en       <= '0;
            pe_row_num      <= '0;
            pe_stride       <= '0;
            pe_weight_data  <= '0;
            pe_weight_valid <= 1'b0;
            pe_ifmap_data   <= '0;
            pe_ifmap_valid  <= 1'b0;
            pe_reset_ifmap  <= 1'b0;
            r_wcnt          <= '0;
            r_wtarget       <= '0;
            r_xcnt          <= '0;
            r_ifmap_len     <= '0;
            r_out_cnt       <= '0;
            r_out_count     <= '0;
        end else begin
            cfg_err         <= w_start_bad;
            pe_reset_ifmap  <= (r_state == ST_LOAD_W) && (w_state_next == ST_LOAD_I);
            pe_weight_valid <= w_w_acc;
            pe_ifmap_valid  <= w_x_acc;
            if (w_w_acc) pe_weight_data <= w_data;
            if (w_x_acc) pe_ifmap_data  <= x_data;
            if (w_start_ok) begin
                pe_filter_width <= cfg_filter_width;
                pe_row_num      <= cfg_row_num;
                pe_stride       <= cfg_stride;
                pe_row_en       <= w_row_en;
                r_wtarget       <= WCNT_W'(cfg_filter_width) * WCNT_W'(cfg_row_num);
                r_ifmap_len     <= cfg_ifmap_len;
                r_out_count     <= cfg_out_count;
                r_wcnt          <= '0;
                r_xcnt          <= '0;
                r_out_cnt       <= '0;
                ovf_err         <= 1'b0;
            end else begin
                if (w_ovf)                   ovf_err   <= 1'b1;
                if (w_w_acc)                 r_wcnt    <= r_wcnt + WCNT_ONE;
                if (w_x_acc)                 r_xcnt    <= r_xcnt + LEN_ONE;
                if (pe_peout_valid && busy)  r_out_cnt <= r_out_cnt + LEN_ONE;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_fifo_cnt <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + PTR_ONE;
            if (w_pop)     r_rptr <= r_rptr + PTR_ONE;
            case ({w_do_push, w_pop})
                2'b10:   r_fifo_cnt <= r_fifo_cnt + FCNT_ONE;
                2'b01:   r_fifo_cnt <= r_fifo_cnt - FCNT_ONE;
                default: r_fifo_cnt <= r_fifo_cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wptr] <= pe_peout_data;
    end

endmodule

// File: tb/tb_pe_cluster_ctrl.sv
// Directed bench for pe_cluster_ctrl: config checks, weight/ifmap sequencing, FIFO skid and overflow, async reset.
module tb_pe_cluster_ctrl;

    logic        clk = 1'b0;
    logic        reset, start;
    logic [4:0]  cfg_filter_width, cfg_row_num, cfg_stride;
    logic [15:0] cfg_ifmap_len, cfg_out_count;
    logic        busy, done, cfg_err, ovf_err;
    logic [15:0] w_data, x_data;
    logic        w_valid, w_ready, x_valid, x_ready;
    logic [4:0]  pe_filter_width, pe_row_num, pe_stride;
    logic [15:0] pe_row_en;
    logic [15:0] pe_weight_data, pe_ifmap_data, pe_peout_data, o_data;
    logic        pe_weight_valid, pe_ifmap_valid, pe_reset_ifmap, pe_peout_valid;
    logic        o_valid, o_ready;

    pe_cluster_ctrl #(
        .DATA_WIDTH(16), .MAX_FILTER_WIDTH(11), .MAX_ROW_NUM(16),
        .LEN_WIDTH(16), .OFIFO_DEPTH(8), .SKID(4)
    ) dut (
        .clk(clk), .reset(reset), .start(start),
        .cfg_filter_width(cfg_filter_width), .cfg_row_num(cfg_row_num),
        .cfg_stride(cfg_stride), .cfg_ifmap_len(cfg_ifmap_len), .cfg_out_count(cfg_out_count),
        .busy(busy), .done(done), .cfg_err(cfg_err), .ovf_err(ovf_err),
        .w_data(w_data), .w_valid(w_valid), .w_ready(w_ready),
        .x_data(x_data), .x_valid(x_valid), .x_ready(x_ready),
        .pe_filter_width(pe_filter_width), .pe_row_en(pe_row_en), .pe_row_num(pe_row_num),
        .pe_stride(pe_stride), .pe_weight_data(pe_weight_data), .pe_weight_valid(pe_weight_valid),
        .pe_ifmap_data(pe_ifmap_data), .pe_ifmap_valid(pe_ifmap_valid),
        .pe_reset_ifmap(pe_reset_ifmap), .pe_peout_data(pe_peout_data),
        .pe_peout_valid(pe_peout_valid), .o_data(o_data), .o_valid(o_valid), .o_ready(o_ready)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [15:0] wq[$];
    int          wcq[$];
    int          wacq[$];
    logic [15:0] xq[$];
    int          xcq[$];
    logic [15:0] oq[$];
    int          rst_cnt, rst_cyc, done_cnt;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (pe_weight_valid) begin wq.push_back(pe_weight_data); wcq.push_back(cyc); end
        if (pe_ifmap_valid)  begin xq.push_back(pe_ifmap_data);  xcq.push_back(cyc); end
        if (pe_reset_ifmap)  begin rst_cnt++; rst_cyc = cyc; end
        if (o_valid && o_ready) oq.push_back(o_data);
        if (done) done_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        wq.delete(); wcq.delete(); wacq.delete(); xq.delete(); xcq.delete(); oq.delete();
        rst_cnt = 0; rst_cyc = -1; done_cnt = 0;
    endtask

    task automatic start_job(input int f, input int r, input int s, input int n, input int m);
        cfg_filter_width = 5'(f); cfg_row_num = 5'(r); cfg_stride = 5'(s);
        cfg_ifmap_len = 16'(n); cfg_out_count = 16'(m);
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    // Drives both sources until nw weights and nx ifmap words have been accepted.
    task automatic stream(input int nw, input int nx, input bit wtog,
                          input logic [15:0] wbase, input logic [15:0] xbase, output bit ok);
        int wi = 0;
        int xi = 0;
        bit wacc, xacc;
        ok = 1'b0;
        for (int c = 0; c < 300; c++) begin
            if (wi == nw && xi == nx) begin ok = 1'b1; break; end
            w_valid = (wi < nw) && (!wtog || (c % 2 == 0));
            w_data  = wbase + 16'(wi);
            x_valid = (xi < nx);
            x_data  = xbase + 16'(xi);
            wacc = w_valid && w_ready;
            xacc = x_valid && x_ready;
            if (wacc) wacq.push_back(cyc);
            tick(1);
            if (wacc) wi++;
            if (xacc) xi++;
        end
        if (wi == nw && xi == nx) ok = 1'b1;
        w_valid = 1'b0;
        x_valid = 1'b0;
    endtask

    task automatic pulse(input logic [15:0] d);
        pe_peout_valid = 1'b1;
        pe_peout_data  = d;
        tick(1);
        pe_peout_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        bit got;
        reset = 1'b1; start = 1'b0;
        cfg_filter_width = '0; cfg_row_num = '0; cfg_stride = '0;
        cfg_ifmap_len = '0; cfg_out_count = '0;
        w_data = '0; w_valid = 1'b0; x_data = '0; x_valid = 1'b0;
        pe_peout_data = '0; pe_peout_valid = 1'b0; o_ready = 1'b0;
        clear_mon();
        tick(2);
        reset = 1'b0;
        tick(1);

        check("rst_busy", busy, 0);
        check("rst_ovalid", o_valid, 0);
        check("rst_rowen", pe_row_en, 0);
        check("rst_wready", w_ready, 0);
        check("rst_ovf", ovf_err, 0);

        // Illegal configurations
        clear_mon();
        start_job(0, 2, 1, 8, 6);
        check("f0_cfgerr", cfg_err, 1);
        check("f0_busy", busy, 0);
        tick(1);
        check("f0_cfgerr_pulse", cfg_err, 0);
        start_job(12, 2, 1, 8, 6);
        check("f12_cfgerr", cfg_err, 1);
        check("f12_busy", busy, 0);
        tick(1);
        start_job(3, 17, 1, 8, 6);
        check("r17_cfgerr", cfg_err, 1);
        check("r17_busy", busy, 0);
        tick(2);
        check("bad_no_wstrobe", wq.size(), 0);
        check("bad_no_rowen", pe_row_en, 0);

        // F=3 R=2 N=8 M=6, sources always valid
        clear_mon();
        o_ready = 1'b1;
        start_job(3, 2, 1, 8, 6);
        check("j2_busy", busy, 1);
        check("j2_rowen", pe_row_en, 16'h0003);
        check("j2_fw", pe_filter_width, 3);
        check("j2_rn", pe_row_num, 2);
        check("j2_wready", w_ready, 1);
        stream(6, 8, 1'b0, 16'hA000, 16'hB000, ok);
        check("j2_stream_done", ok, 1);
        tick(1);
        check("j2_wcount", wq.size(), 6);
        for (int i = 0; i < 6 && i < wq.size(); i++) check("j2_wdata", wq[i], 16'hA000 + 16'(i));
        check("j2_rstcnt", rst_cnt, 1);
        check("j2_xcount", xq.size(), 8);
        for (int i = 0; i < 8 && i < xq.size(); i++) check("j2_xdata", xq[i], 16'hB000 + 16'(i));
        if (wcq.size() == 6) check("j2_rst_after_w", rst_cyc, wcq[5]);
        if (xcq.size() > 0)  check("j2_x_after_rst", xcq[0], rst_cyc + 2);
        for (int k = 0; k < 6; k++) begin
            check("j2_nodone_early", done, 0);
            pulse(16'hC000 + 16'(k));
        end
        check("j2_done_wait", done, 0);
        tick(1);
        check("j2_done", done, 1);
        check("j2_busy_done", busy, 1);
        tick(1);
        check("j2_done_pulse", done, 0);
        check("j2_busy_idle", busy, 0);
        check("j2_donecnt", done_cnt, 1);
        check("j2_ocount", oq.size(), 6);
        for (int i = 0; i < 6 && i < oq.size(); i++) check("j2_odata", oq[i], 16'hC000 + 16'(i));
        o_ready = 1'b0;

        // F=2 R=1 with toggling weight valid
        clear_mon();
        o_ready = 1'b1;
        start_job(2, 1, 1, 2, 2);
        stream(2, 2, 1'b1, 16'h1230, 16'h4560, ok);
        check("j3_stream_done", ok, 1);
        tick(1);
        check("j3_wcount", wq.size(), 2);
        check("j3_acccount", wacq.size(), 2);
        for (int i = 0; i < 2 && i < wq.size() && i < wacq.size(); i++) begin
            check("j3_wdata", wq[i], 16'h1230 + 16'(i));
            check("j3_wlat", wcq[i], wacq[i] + 1);
        end
        if (wacq.size() == 2) check("j3_acc_gap", wacq[1] - wacq[0], 2);
        pulse(16'h7000);
        pulse(16'h7001);
        got = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (done) begin got = 1'b1; break; end
            tick(1);
        end
        check("j3_done", got, 1);
        tick(2);
        o_ready = 1'b0;

        // Skid gating: x_ready drops at 4 stored outputs
        clear_mon();
        start_job(1, 1, 1, 8, 4);
        stream(1, 0, 1'b0, 16'h0055, 16'h0000, ok);
        check("j5_stream_w", ok, 1);
        check("j5_rst_ifmap", pe_reset_ifmap, 1);
        check("j5_xready_first", x_ready, 0);
        tick(1);
        check("j5_rst_pulse", pe_reset_ifmap, 0);
        check("j5_xready_open", x_ready, 1);
        for (int k = 0; k < 4; k++) begin
            if (k == 3) check("j5_xready_cnt3", x_ready, 1);
            pulse(16'hD000 + 16'(k));
        end
        check("j5_xready_cnt4", x_ready, 0);
        check("j5_ovalid", o_valid, 1);
        check("j5_ohead", o_data, 16'hD000);
        oq.delete();
        o_ready = 1'b1;
        tick(1);
        check("j5_xready_resume", x_ready, 1);
        stream(0, 8, 1'b0, 16'h0000, 16'hB100, ok);
        check("j5_stream_x", ok, 1);
        got = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (done) begin got = 1'b1; break; end
            tick(1);
        end
        check("j5_done", got, 1);
        check("j5_xcount", xq.size(), 8);
        check("j5_ocount", oq.size(), 4);
        for (int i = 0; i < 4 && i < oq.size(); i++) check("j5_odata", oq[i], 16'hD000 + 16'(i));
        o_ready = 1'b0;
        tick(2);

        // Overflow: 9 pulses into an 8-deep FIFO
        clear_mon();
        start_job(1, 1, 1, 1, 9);
        stream(1, 1, 1'b0, 16'h0066, 16'h0077, ok);
        check("j6_stream", ok, 1);
        for (int k = 0; k < 9; k++) begin
            if (k == 8) check("j6_no_ovf_at8", ovf_err, 0);
            pulse(16'hE000 + 16'(k));
        end
        check("j6_ovf", ovf_err, 1);
        tick(1);
        check("j6_done_cnt9", done, 1);
        tick(1);
        check("j6_idle", busy, 0);
        check("j6_ovf_sticky", ovf_err, 1);
        o_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            check("j6_odata", o_data, 16'hE000 + 16'(k));
            tick(1);
        end
        check("j6_empty", o_valid, 0);
        o_ready = 1'b0;

        // Async reset in the middle of LOAD_I
        clear_mon();
        start_job(1, 1, 1, 4, 1);
        stream(1, 1, 1'b0, 16'h0088, 16'h0099, ok);
        check("j1_stream", ok, 1);
        pulse(16'hF000);
        check("j1_busy_pre", busy, 1);
        check("j1_ovalid_pre", o_valid, 1);
        #2;
        reset = 1'b1;
        #1;
        check("j1_busy_async", busy, 0);
        check("j1_ovalid_async", o_valid, 0);
        check("j1_odata_async", o_data, 0);
        check("j1_rowen_async", pe_row_en, 0);
        check("j1_fw_async", pe_filter_width, 0);
        check("j1_ovf_async", ovf_err, 0);
        tick(1);
        reset = 1'b0;
        tick(1);
        o_ready = 1'b1;
        start_job(2, 3, 1, 2, 1);
        check("j1_restart_busy", busy, 1);
        check("j1_restart_rowen", pe_row_en, 16'h0007);
        check("j1_restart_wready", w_ready, 1);
        stream(6, 2, 1'b0, 16'h3000, 16'h3100, ok);
        check("j1_restart_stream", ok, 1);
        pulse(16'h3200);
        got = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (done) begin got = 1'b1; break; end
            tick(1);
        end
        check("j1_restart_done", got, 1);
        tick(3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
